// File: rtl/ex_mem_pipe_pkg.sv
// rtl/ex_mem_pipe_pkg.sv - shared constants and types for the EX->MEM pipe boundary
package ex_mem_pipe_pkg;

  localparam int WB_REGWRITE_BIT = 0;

  // Entry layout is {wb, mem, rd, alu, wdata}, MSB first, in every pipe stage.
  function automatic int payload_width(input int wb_w, input int mem_w,
                                       input int reg_w, input int data_w);
    return wb_w + mem_w + reg_w + 2 * data_w;
  endfunction

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IN   = 2'd1,
    SRC_SKID = 2'd2
  } m_src_e;

endpackage

// File: rtl/ex_mem_pipe_slot.sv
// rtl/ex_mem_pipe_slot.sv - one valid bit plus payload register with load and clear
module ex_mem_pipe_slot #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Clear wins over load so a flush cannot be undone by a same-cycle capture.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX->MEM boundary: 2-entry skid buffer, flush, stall counter, forwarding tap
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int WB_W    = 2,
  parameter int MEM_W   = 3,
  parameter int CNT_W   = 16,
  parameter int ZERO_SQ = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   in_wb,
  input  logic [MEM_W-1:0]  in_mem,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   out_wb,
  output logic [MEM_W-1:0]  out_mem,
  output logic [REG_W-1:0]  out_rd,
  output logic [DATA_W-1:0] out_alu,
  output logic [DATA_W-1:0] out_wdata,
  output logic              fwd_en,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PW = payload_width(WB_W, MEM_W, REG_W, DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WB_W-1:0] wb_cap;
  logic [PW-1:0]   in_pay, m_pay, s_pay, m_din;
  logic            m_valid, s_valid;
  logic            accept, drain;
  logic            m_load, m_clear, s_load, s_clear;
  m_src_e          m_src;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Writes to x0 are architecturally dead, so drop RegWrite before it reaches the hazard unit.
  always_comb begin
    wb_cap = in_wb;
    if (ZERO_SQ != 0 && in_rd == '0) wb_cap[WB_REGWRITE_BIT] = 1'b0;
  end

  assign in_pay   = {wb_cap, in_mem, in_rd, in_alu, in_wdata};
  assign in_ready = !s_valid;
  assign accept   = in_valid && in_ready;
  assign drain    = m_valid && out_ready;

  always_comb begin
    m_src   = SRC_NONE;
    m_clear = 1'b0;
    s_load  = 1'b0;
    s_clear = 1'b0;
    if (flush) begin
      m_clear = 1'b1;
      s_clear = 1'b1;
    end else if (!m_valid) begin
      if (accept) m_src = SRC_IN;
    end else if (drain) begin
      if (s_valid) begin
        m_src   = SRC_SKID;
        s_clear = 1'b1;
      end else if (accept) begin
        m_src = SRC_IN;
      end else begin
        m_clear = 1'b1;
      end
    end else if (accept) begin
      s_load = 1'b1;
    end
  end

  assign m_load = (m_src != SRC_NONE);
  assign m_din  = (m_src == SRC_SKID) ? s_pay : in_pay;

  ex_mem_pipe_slot #(.W(PW)) u_slot_m (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (m_load),
    .clear_i (m_clear),
    .data_i  (m_din),
    .valid_o (m_valid),
    .data_o  (m_pay)
  );

  ex_mem_pipe_slot #(.W(PW)) u_slot_s (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (s_load),
    .clear_i (s_clear),
    .data_i  (in_pay),
    .valid_o (s_valid),
    .data_o  (s_pay)
  );

  assign out_valid = m_valid;
  assign {out_wb, out_mem, out_rd, out_alu, out_wdata} = m_pay;
  assign fwd_en    = m_valid && out_wb[WB_REGWRITE_BIT];

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule
